// File: rtl/modulation_pipe_pkg.sv
// Shared constants and types for the modulation pipe: segment word width,
// default segments per symbol and the drop-counter width with its saturating increment.
package modulation_pipe_pkg;

    localparam int SEG_W            = 32;
    localparam int SEGS_PER_SYM_DEF = 4;
    localparam int DROP_CNT_W       = 16;

    typedef logic [SEG_W-1:0] seg_word_t;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mod_segment_streamer_seg_fifo_core.sv
// Storage, pointers and occupancy for the segment FIFO; head word is read combinationally
// (first-word-fall-through). Caller must never push when full unless it also pops.
module seg_fifo_core
    import modulation_pipe_pkg::*;
#(
    parameter int DATA_W = SEG_W,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Full-with-pop writes the slot being read this cycle; the old word leaves on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/mod_segment_streamer.sv
// Segment word FIFO with valid/ready output and symbol-boundary marker; 1-cycle fall-through,
// input never stalls (words arriving when full are dropped). Optional STREAMER_DROP_CNT_EN adds drop_count.
module mod_segment_streamer
    import modulation_pipe_pkg::*;
#(
    parameter int DATA_W       = SEG_W,
    parameter int DEPTH        = 8,
    parameter int SEGS_PER_SYM = SEGS_PER_SYM_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
`ifdef STREAMER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]    drop_count
`endif
);

    localparam int LVL_W     = $clog2(DEPTH) + 1;
    localparam int SEG_IDX_W = (SEGS_PER_SYM > 1) ? $clog2(SEGS_PER_SYM) : 1;

    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 seg_wrap;
    logic [SEG_IDX_W-1:0] seg_idx;

    assign full      = (level == LVL_W'(DEPTH));
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign drop      = in_valid && full && !pop;
    assign push      = in_valid && !drop;
    assign seg_wrap  = (seg_idx == SEG_IDX_W'(SEGS_PER_SYM - 1));
    assign out_last  = out_valid && seg_wrap;

    seg_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (out_data),
        .level   (level)
    );

    // Drops leave seg_idx alone: alignment after an overflow is the consumer's problem.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_idx  <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                seg_idx <= seg_wrap ? '0 : seg_idx + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef STREAMER_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop) begin
            drop_count <= sat_inc(drop_count);
        end
    end
`endif

endmodule

// File: tb/tb_mod_segment_streamer.sv
// Directed bench for mod_segment_streamer with a queue scoreboard: a model process predicts
// accepted words and occupancy, a monitor pops and compares every handshaked output word.
module tb_mod_segment_streamer;
    import modulation_pipe_pkg::*;

    localparam int DEPTH = 8;
    localparam int SPS   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    seg_word_t   in_data;
    logic        out_valid;
    logic        out_ready;
    seg_word_t   out_data;
    logic        out_last;
    logic [3:0]  level;
    logic        overflow;
`ifdef STREAMER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_count;
`endif

    mod_segment_streamer #(
        .DATA_W       (SEG_W),
        .DEPTH        (DEPTH),
        .SEGS_PER_SYM (SPS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .level      (level),
        .overflow   (overflow)
`ifdef STREAMER_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int        n_chk  = 0;
    int        n_pass = 0;
    seg_word_t exp_q [$];
    int        m_level = 0;
    bit        m_ovf   = 1'b0;
    int        m_drop  = 0;
    int        m_seg   = 0;
    seg_word_t w1 [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: checks current state, then predicts what the coming edge accepts or drops.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_level = 0;
            m_ovf   = 1'b0;
            m_drop  = 0;
        end else begin
            bit m_pop;
            bit m_push;
            check("level", level, m_level);
            check("out_valid", out_valid, m_level != 0);
            check("overflow", overflow, m_ovf);
            m_pop  = (m_level > 0) && out_ready;
            m_push = 1'b0;
            if (in_valid) begin
                if (m_level < DEPTH || m_pop) begin
                    m_push = 1'b1;
                    exp_q.push_back(in_data);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
            m_level = m_level + int'(m_push) - int'(m_pop);
        end
    end

    // Monitor: every accepted output word must be the oldest predicted word.
    always @(negedge clk) begin
        if (reset) begin
            m_seg = 0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", out_data, 64'hDEAD_BEEF_0000_0000);
            end else begin
                seg_word_t e;
                e = exp_q.pop_front();
                check("out_data", out_data, e);
                check("out_last", out_last, m_seg == SPS - 1);
            end
            m_seg = (m_seg + 1) % SPS;
        end
    end

    task automatic drain(input int budget);
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (level != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", level, 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
`ifdef STREAMER_DROP_CNT_EN
        check("rst_drop_count", drop_count, 0);
`endif

        // Back-to-back pass-through, one-cycle fall-through latency.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = w1[i];
            tick();
            check("ft_valid", out_valid, 1);
            check("ft_data", out_data, w1[i]);
            check("ft_last", out_last, i == 3);
            check("ft_level", level, 1);
        end
        in_valid = 1'b0;
        tick();
        tick();

        // Fill, then one dropped word.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + i;
            tick();
        end
        check("full_level", level, 8);
        in_data = 32'h999;
        tick();
        in_valid = 1'b0;
        check("drop_overflow", overflow, 1);
        check("drop_level", level, 8);
        check("drop_head", out_data, 32'h100);
`ifdef STREAMER_DROP_CNT_EN
        check("drop_count_1", drop_count, 1);
`endif

        // Full with simultaneous push/pop: no drops, level constant.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h200 + i;
            tick();
            check("pp_level", level, 8);
        end
        drain(40);

`ifdef STREAMER_DROP_CNT_EN
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < DEPTH + 65600; i++) begin
            in_data = 32'h3000 + i;
            tick();
        end
        in_valid = 1'b0;
        check("sat_drop_count", drop_count, 16'hFFFF);
        check("sat_overflow", overflow, 1);
        drain(40);
`endif

        // Reset mid-stream discards contents and restarts symbol alignment.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h400 + i;
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_valid", out_valid, 0);
        check("mrst_level", level, 0);
        check("mrst_overflow", overflow, 0);
`ifdef STREAMER_DROP_CNT_EN
        check("mrst_drop_count", drop_count, 0);
`endif
        in_valid = 1'b1;
        in_data  = 32'hA5;
        tick();
        in_valid = 1'b0;
        check("a5_valid", out_valid, 1);
        check("a5_data", out_data, 32'hA5);
        check("a5_last", out_last, 0);
        drain(10);

        // Random consumer, producer every other cycle; ready forced near full to keep it lossless.
        for (int i = 0; i < 2000; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 32'h5000_0000 + i;
            out_ready = (m_level >= DEPTH - 2) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
        end
        drain(40);
        check("rand_overflow", overflow, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
